// File: rtl/duty_sequencer_if.sv
// Duty/mode bus between the breathing sequencer and the downstream PWM stage.
// The sequencer side (master) sources DUTY/MODE; the PWM side (slave) sources PWM_WRAP.
interface duty_sequencer_if;
    logic        PWM_WRAP;
    logic [20:0] DUTY;
    logic        DUTY_VALID;
    logic [1:0]  MODE;

    modport master (input PWM_WRAP, output DUTY, output DUTY_VALID, output MODE);
    modport slave  (output PWM_WRAP, input DUTY, input DUTY_VALID, input MODE);
endinterface

// File: rtl/duty_sequencer.sv
// Button-driven LED brightness sequencer: OFF / ON / slow breathing / fast breathing.
// DUTY is only ever updated right after a PWM period boundary so the PWM never glitches.
//
//   state | meaning
//   OFF   | DUTY 0 on every wrap
//   ON    | DUTY PERIOD on every wrap
//   SLOW  | triangle breathing, one level step every SLOW_DIV wraps
//   FAST  | triangle breathing, one level step every FAST_DIV wraps
module duty_sequencer #(
    parameter logic [20:0] PERIOD          = 21'd12000,
    parameter int          STEPS           = 50,
    parameter int          SLOW_DIV        = 10,
    parameter int          FAST_DIV        = 3,
    parameter int          DEBOUNCE_CYCLES = 120000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BTN,
    duty_sequencer_if.master bus
);

    localparam logic [20:0] STEP    = PERIOD / 21'(STEPS);
    localparam int          LVL_W   = $clog2(STEPS + 1);
    localparam int          DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int          DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int          DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        ON   = 2'd1,
        SLOW = 2'd2,
        FAST = 2'd3
    } mode_t;

    logic             btn_meta;
    logic             btn_sync;
    logic             btn_stable;
    logic [DB_W-1:0]  db_cnt;
    logic             press_q;

    mode_t            state;
    logic [LVL_W-1:0] level;
    logic             dir_up;
    logic [DIV_W-1:0] div_cnt;
    logic [20:0]      duty_q;
    logic             duty_valid_q;

    logic [LVL_W-1:0] lvl_nxt;
    logic             dir_nxt;
    logic [DIV_W-1:0] div_lim;

    // press_q pulses one cycle when the debounced level rises
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            btn_stable <= 1'b0;
            db_cnt     <= '0;
            press_q    <= 1'b0;
        end else begin
            btn_meta <= BTN;
            btn_sync <= btn_meta;
            press_q  <= 1'b0;
            if (btn_sync == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_stable <= btn_sync;
                db_cnt     <= '0;
                press_q    <= btn_sync;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Triangle turns at the endpoints so neither 0 nor STEPS is emitted twice in a row
    always_comb begin
        lvl_nxt = level;
        dir_nxt = dir_up;
        if (dir_up) begin
            if (level == LVL_W'(STEPS)) begin
                lvl_nxt = LVL_W'(STEPS - 1);
                dir_nxt = 1'b0;
            end else begin
                lvl_nxt = level + LVL_W'(1);
            end
        end else begin
            if (level == '0) begin
                lvl_nxt = LVL_W'(1);
                dir_nxt = 1'b1;
            end else begin
                lvl_nxt = level - LVL_W'(1);
            end
        end
        div_lim = (state == FAST) ? DIV_W'(FAST_DIV - 1) : DIV_W'(SLOW_DIV - 1);
    end

    // Press handling sits after the wrap update so its divider/level clears win
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= OFF;
            level        <= '0;
            dir_up       <= 1'b1;
            div_cnt      <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            duty_valid_q <= 1'b0;
            if (bus.PWM_WRAP) begin
                duty_valid_q <= 1'b1;
                case (state)
                    OFF:     duty_q <= '0;
                    ON:      duty_q <= PERIOD;
                    default: begin
                        if (div_cnt == div_lim) begin
                            level   <= lvl_nxt;
                            dir_up  <= dir_nxt;
                            div_cnt <= '0;
                            duty_q  <= 21'(lvl_nxt) * STEP;
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                            duty_q  <= 21'(level) * STEP;
                        end
                    end
                endcase
            end
            if (press_q) begin
                case (state)
                    OFF:  state <= ON;
                    ON: begin
                        state   <= SLOW;
                        level   <= '0;
                        dir_up  <= 1'b1;
                        div_cnt <= '0;
                    end
                    SLOW: begin
                        state   <= FAST;
                        div_cnt <= '0;
                    end
                    default: state <= OFF;
                endcase
            end
        end
    end

    assign bus.DUTY       = duty_q;
    assign bus.DUTY_VALID = duty_valid_q;
    assign bus.MODE       = state;

endmodule

// File: tb/tb_duty_sequencer.sv
// Directed bench for duty_sequencer with small parameters (PERIOD 100, STEPS 10, DIV 2/1, debounce 8).
module tb_duty_sequencer;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    logic BTN   = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    duty_sequencer_if bus ();

    duty_sequencer #(
        .PERIOD         (21'd100),
        .STEPS          (10),
        .SLOW_DIV       (2),
        .FAST_DIV       (1),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .BTN  (BTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle wrap; checks the update, the strobe width and that DUTY holds afterwards
    task automatic do_wrap(input string tag, input int exp_duty);
        bus.PWM_WRAP = 1'b1;
        tick();
        bus.PWM_WRAP = 1'b0;
        chk_val({tag, "_duty"}, 32'(bus.DUTY), 32'(exp_duty));
        chk_val({tag, "_vld"}, 32'(bus.DUTY_VALID), 32'd1);
        tick();
        chk_val({tag, "_vld_lo"}, 32'(bus.DUTY_VALID), 32'd0);
        chk_val({tag, "_hold"}, 32'(bus.DUTY), 32'(exp_duty));
    endtask

    task automatic press(input string tag, input int exp_mode);
        BTN = 1'b1;
        repeat (20) tick();
        chk_val({tag, "_mode"}, 32'(bus.MODE), 32'(exp_mode));
        BTN = 1'b0;
        repeat (20) tick();
        chk_val({tag, "_rel"}, 32'(bus.MODE), 32'(exp_mode));
    endtask

    initial begin
        bus.PWM_WRAP = 1'b0;
        repeat (3) tick();
        chk_val("rst_duty", 32'(bus.DUTY), 32'd0);
        chk_val("rst_vld", 32'(bus.DUTY_VALID), 32'd0);
        chk_val("rst_mode", 32'(bus.MODE), 32'd0);
        RST_N = 1'b1;
        tick();
        do_wrap("off_wrap", 0);
        chk_val("off_mode", 32'(bus.MODE), 32'd0);

        // Short bounces must not count, then one steady press
        for (int i = 0; i < 4; i++) begin
            BTN = 1'b1;
            repeat (3) tick();
            BTN = 1'b0;
            repeat (3) tick();
        end
        chk_val("bounce_mode", 32'(bus.MODE), 32'd0);
        press("press_on", 1);
        do_wrap("on_wrap", 100);

        press("press_slow", 2);
        for (int k = 1; k <= 22; k++) begin
            int e;
            e = (k <= 20) ? (k / 2) * 10 : ((k == 21) ? 100 : 90);
            do_wrap($sformatf("slow_%0d", k), e);
        end

        // FAST keeps level 9 heading down
        press("press_fast", 3);
        for (int k = 1; k <= 9; k++) begin
            do_wrap($sformatf("fast_%0d", k), (9 - k) * 10);
        end
        do_wrap("fast_turn", 10);

        bus.PWM_WRAP = 1'b1;
        tick();
        chk_val("b2b_1_duty", 32'(bus.DUTY), 32'd20);
        chk_val("b2b_1_vld", 32'(bus.DUTY_VALID), 32'd1);
        tick();
        bus.PWM_WRAP = 1'b0;
        chk_val("b2b_2_duty", 32'(bus.DUTY), 32'd30);
        chk_val("b2b_2_vld", 32'(bus.DUTY_VALID), 32'd1);
        tick();
        chk_val("b2b_vld_lo", 32'(bus.DUTY_VALID), 32'd0);

        press("press_off", 0);
        do_wrap("off2_wrap", 0);
        press("press_on2", 1);
        do_wrap("on2_wrap", 100);

        // Press lands at the 11th edge after BTN rises; put a wrap on that same edge
        BTN = 1'b1;
        repeat (10) tick();
        chk_val("same_pre_mode", 32'(bus.MODE), 32'd1);
        bus.PWM_WRAP = 1'b1;
        tick();
        bus.PWM_WRAP = 1'b0;
        chk_val("same_duty", 32'(bus.DUTY), 32'd100);
        chk_val("same_vld", 32'(bus.DUTY_VALID), 32'd1);
        chk_val("same_mode", 32'(bus.MODE), 32'd2);
        BTN = 1'b0;
        repeat (20) tick();
        chk_val("same_rel_mode", 32'(bus.MODE), 32'd2);
        for (int k = 1; k <= 14; k++) begin
            do_wrap($sformatf("slow2_%0d", k), (k / 2) * 10);
        end

        // Asynchronous reset mid-breath at level 7, button held through release
        BTN = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        chk_val("async_duty", 32'(bus.DUTY), 32'd0);
        chk_val("async_mode", 32'(bus.MODE), 32'd0);
        chk_val("async_vld", 32'(bus.DUTY_VALID), 32'd0);
        repeat (3) tick();
        RST_N = 1'b1;
        tick();
        do_wrap("post_rst_wrap", 0);
        repeat (7) tick();
        chk_val("held_pre_mode", 32'(bus.MODE), 32'd0);
        tick();
        chk_val("held_press_mode", 32'(bus.MODE), 32'd1);
        BTN = 1'b0;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
